// File: rtl/buffer_write_arbiter.sv
// Single owner of the char_buffer write port: merges single-char command writes
// with bulk erase fills, and holds all writes off while the buffer is scrolling.
module buffer_write_arbiter #(
  parameter int COLS      = 80,
  parameter int ROWS      = 24,
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scroll_busy,
  input  logic                 cmd_wen,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [7:0]           cmd_char,
  output logic                 cmd_ready,
  input  logic                 fill_req,
  input  logic [ADDR_BITS-1:0] fill_start,
  input  logic [ADDR_BITS:0]   fill_count,
  input  logic [7:0]           fill_char,
  output logic                 fill_ack,
  output logic                 fill_busy,
  output logic                 fill_done,
  output logic [ADDR_BITS-1:0] buf_waddr,
  output logic [7:0]           buf_din,
  output logic                 buf_wen
);

  localparam int MAX_ADDR = ROWS * COLS - 1;
  localparam logic [ADDR_BITS-1:0] MAX_A = ADDR_BITS'(MAX_ADDR);

  typedef enum logic {IDLE, FILL} state_t;

  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] cur_addr, cur_addr_nxt;
  logic [ADDR_BITS:0]   remaining, remaining_nxt;
  logic [7:0]           fill_chr, fill_chr_nxt;
  logic [ADDR_BITS-1:0] waddr_nxt;
  logic [7:0]           din_nxt;
  logic                 wen_nxt, ack_nxt, done_nxt;

  assign cmd_ready = (state == IDLE) & ~scroll_busy & ~reset;
  assign fill_busy = (state == FILL);

  always_comb begin
    state_nxt     = state;
    cur_addr_nxt  = cur_addr;
    remaining_nxt = remaining;
    fill_chr_nxt  = fill_chr;
    waddr_nxt     = buf_waddr;
    din_nxt       = buf_din;
    wen_nxt       = 1'b0;
    ack_nxt       = 1'b0;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_ready && cmd_wen) begin
          // out-of-range single writes are consumed but never reach the buffer
          if (cmd_addr <= MAX_A) begin
            wen_nxt   = 1'b1;
            waddr_nxt = cmd_addr;
            din_nxt   = cmd_char;
          end
        end else if (fill_req && !scroll_busy) begin
          cur_addr_nxt  = fill_start;
          remaining_nxt = fill_count;
          fill_chr_nxt  = fill_char;
          ack_nxt       = 1'b1;
          state_nxt     = FILL;
        end
      end
      FILL: begin
        if (!scroll_busy) begin
          if (remaining == '0 || cur_addr > MAX_A) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            wen_nxt   = 1'b1;
            waddr_nxt = cur_addr;
            din_nxt   = fill_chr;
            // the MAX_ADDR clip ends the fill before the address could wrap
            if (remaining == (ADDR_BITS+1)'(1) || cur_addr == MAX_A) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              cur_addr_nxt  = cur_addr + 1'b1;
              remaining_nxt = remaining - 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      fill_chr  <= '0;
      buf_waddr <= '0;
      buf_din   <= '0;
      buf_wen   <= 1'b0;
      fill_ack  <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_addr  <= cur_addr_nxt;
      remaining <= remaining_nxt;
      fill_chr  <= fill_chr_nxt;
      buf_waddr <= waddr_nxt;
      buf_din   <= din_nxt;
      buf_wen   <= wen_nxt;
      fill_ack  <= ack_nxt;
      fill_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_buffer_write_arbiter.sv
// Directed bench for buffer_write_arbiter: cycle table plus fill corner-case sequences.
module tb_buffer_write_arbiter;

  logic        clk = 1'b0;
  logic        reset, scroll_busy, cmd_wen, fill_req;
  logic [10:0] cmd_addr, fill_start;
  logic [7:0]  cmd_char, fill_char;
  logic [11:0] fill_count;
  logic        cmd_ready, fill_ack, fill_busy, fill_done, buf_wen;
  logic [10:0] buf_waddr;
  logic [7:0]  buf_din;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  buffer_write_arbiter dut (
    .clk(clk), .reset(reset), .scroll_busy(scroll_busy),
    .cmd_wen(cmd_wen), .cmd_addr(cmd_addr), .cmd_char(cmd_char), .cmd_ready(cmd_ready),
    .fill_req(fill_req), .fill_start(fill_start), .fill_count(fill_count), .fill_char(fill_char),
    .fill_ack(fill_ack), .fill_busy(fill_busy), .fill_done(fill_done),
    .buf_waddr(buf_waddr), .buf_din(buf_din), .buf_wen(buf_wen)
  );

  typedef struct {
    logic        rst, sb, cw;
    logic [10:0] ca;
    logic [7:0]  cc;
    logic        fr;
    logic [10:0] fs;
    logic [11:0] fc;
    logic [7:0]  fch;
    logic        e_rdy, e_wen;
    logic [10:0] e_wa;
    logic [7:0]  e_din;
    logic        e_ack, e_busy, e_done;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    reset = 0; scroll_busy = 0; cmd_wen = 0; cmd_addr = 0; cmd_char = 0;
    fill_req = 0; fill_start = 0; fill_count = 0; fill_char = 0;
  endtask

  task automatic start_fill(input logic [10:0] s, input logic [11:0] c, input logic [7:0] ch);
    fill_req = 1; fill_start = s; fill_count = c; fill_char = ch;
    tick();
    chk("fill_ack", fill_ack, 1);
    fill_req = 0;
  endtask

  initial begin
    int n, exp_addr, first_a, last_a;
    bit seen;
    quiet();
    //             rst sb cw  ca     cc    fr  fs     fc   fch   rdy wen wa   din   ack busy done
    vecs[0]  = '{1, 0, 0, 0,    8'h00, 0, 0,    0,   8'h00, 0, 0, 0,   8'h00, 0, 0, 0};
    vecs[1]  = '{0, 0, 1, 5,    8'h41, 0, 0,    0,   8'h00, 1, 1, 5,   8'h41, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0,    8'h00, 0, 0,    0,   8'h00, 1, 0, 5,   8'h41, 0, 0, 0};
    vecs[3]  = '{0, 0, 1, 2000, 8'h42, 0, 0,    0,   8'h00, 1, 0, 5,   8'h41, 0, 0, 0};
    vecs[4]  = '{0, 1, 1, 7,    8'h43, 0, 0,    0,   8'h00, 0, 0, 5,   8'h41, 0, 0, 0};
    vecs[5]  = '{0, 0, 1, 10,   8'h44, 1, 50,   3,   8'h20, 1, 1, 10,  8'h44, 0, 0, 0};
    vecs[6]  = '{0, 0, 0, 0,    8'h00, 1, 50,   3,   8'h20, 1, 0, 10,  8'h44, 1, 1, 0};
    vecs[7]  = '{0, 0, 1, 11,   8'h45, 0, 0,    0,   8'h00, 0, 1, 50,  8'h20, 0, 1, 0};
    vecs[8]  = '{0, 0, 1, 11,   8'h45, 0, 0,    0,   8'h00, 0, 1, 51,  8'h20, 0, 1, 0};
    vecs[9]  = '{0, 0, 1, 11,   8'h45, 0, 0,    0,   8'h00, 0, 1, 52,  8'h20, 0, 0, 1};
    vecs[10] = '{0, 0, 1, 11,   8'h45, 0, 0,    0,   8'h00, 1, 1, 11,  8'h45, 0, 0, 0};
    vecs[11] = '{0, 0, 0, 0,    8'h00, 1, 0,    0,   8'h20, 1, 0, 11,  8'h45, 1, 1, 0};
    vecs[12] = '{0, 0, 0, 0,    8'h00, 0, 0,    0,   8'h00, 0, 0, 11,  8'h45, 0, 0, 1};
    vecs[13] = '{0, 0, 0, 0,    8'h00, 1, 2000, 5,   8'h20, 1, 0, 11,  8'h45, 1, 1, 0};
    vecs[14] = '{0, 0, 0, 0,    8'h00, 0, 0,    0,   8'h00, 0, 0, 11,  8'h45, 0, 0, 1};
    vecs[15] = '{0, 0, 0, 0,    8'h00, 0, 0,    0,   8'h00, 1, 0, 11,  8'h45, 0, 0, 0};
    vecs[16] = '{0, 1, 0, 0,    8'h00, 1, 0,    2,   8'h20, 0, 0, 11,  8'h45, 0, 0, 0};

    #2;
    foreach (vecs[i]) begin
      reset = vecs[i].rst; scroll_busy = vecs[i].sb; cmd_wen = vecs[i].cw;
      cmd_addr = vecs[i].ca; cmd_char = vecs[i].cc; fill_req = vecs[i].fr;
      fill_start = vecs[i].fs; fill_count = vecs[i].fc; fill_char = vecs[i].fch;
      #1;
      chk($sformatf("v%0d cmd_ready", i), cmd_ready, vecs[i].e_rdy);
      tick();
      chk($sformatf("v%0d buf_wen", i), buf_wen, vecs[i].e_wen);
      chk($sformatf("v%0d buf_waddr", i), buf_waddr, vecs[i].e_wa);
      chk($sformatf("v%0d buf_din", i), buf_din, vecs[i].e_din);
      chk($sformatf("v%0d fill_ack", i), fill_ack, vecs[i].e_ack);
      chk($sformatf("v%0d fill_busy", i), fill_busy, vecs[i].e_busy);
      chk($sformatf("v%0d fill_done", i), fill_done, vecs[i].e_done);
    end
    quiet();
    tick();

    // clear screen: 1920 back-to-back writes, done on the last one
    start_fill(0, 1920, 8'h20);
    n = 0;
    for (int c = 0; c < 1920; c++) begin
      chk("cls cmd_ready", cmd_ready, 0);
      tick();
      if (buf_wen !== 1'b1 || buf_waddr !== 11'(c) || buf_din !== 8'h20) n++;
      chk("cls fill_done", fill_done, (c == 1919));
    end
    chk("cls bad writes", n, 0);
    tick();
    chk("cls idle wen", buf_wen, 0);
    chk("cls idle busy", fill_busy, 0);

    // scroll stall at fill address 100
    start_fill(90, 20, 8'h2a);
    exp_addr = 90;
    for (int c = 0; c < 30; c++) begin
      scroll_busy = (c >= 10 && c < 20);
      tick();
      chk("stall fill_busy", fill_busy, (c < 29));
      if (c >= 10 && c < 20) chk("stall no wen", buf_wen, 0);
      else begin
        chk("stall wen", buf_wen, 1);
        chk("stall addr", buf_waddr, exp_addr);
        exp_addr++;
      end
      chk("stall done", fill_done, (c == 29));
    end
    scroll_busy = 0;
    tick();

    // clip at MAX_ADDR
    start_fill(1900, 80, 8'h20);
    n = 0; seen = 0; first_a = -1; last_a = -1;
    for (int c = 0; c < 200 && !seen; c++) begin
      tick();
      if (buf_wen) begin
        if (n == 0) first_a = buf_waddr;
        last_a = buf_waddr;
        n++;
      end
      if (fill_done) seen = 1;
    end
    chk("clip done seen", seen, 1);
    chk("clip writes", n, 20);
    chk("clip first", first_a, 1900);
    chk("clip last", last_a, 1919);

    // reset mid-fill at address 500
    tick();
    start_fill(480, 100, 8'h20);
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      tick();
      if (buf_wen && buf_waddr == 11'd500) seen = 1;
    end
    chk("rst reached 500", seen, 1);
    reset = 1;
    #1;
    chk("rst cmd_ready low", cmd_ready, 0);
    tick();
    chk("rst wen", buf_wen, 0);
    chk("rst busy", fill_busy, 0);
    chk("rst done", fill_done, 0);
    reset = 0;
    #1;
    chk("rst cmd_ready", cmd_ready, 1);
    n = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (buf_wen || fill_done || fill_busy) n++;
    end
    chk("rst quiet after", n, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
